// File: rtl/ysyx_20020207_lsu.sv
// -----------------------------------------------------------------------------
// ysyx_20020207_lsu
//
// Load/store unit of the 32-bit multi-cycle RISC-V core. Takes one instruction
// from execute, runs at most one data-memory access over a valid/ready port,
// formats load data (or passes the ALU result through), and pulses
// lsu_finish for one cycle to qualify the register-file write of wb_data.
//
// Parameters
//   MAX_WAIT    cycles to wait for mem_ready before aborting (0 = forever)
//
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are not
//                         issued; they finish immediately with lsu_fault=1.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   exu_valid/ready     instruction handshake with execute
//   is_load, is_store   memory op type (never both high)
//   funct3              RV32I width/sign code
//   addr                effective address
//   store_data          rs2 value
//   alu_result          writeback value for non-memory ops
//   lsu_finish          one-cycle writeback strobe
//   wb_data, lsu_fault  writeback value and fault flag, valid with lsu_finish
//   mem_valid/mem_wen   memory request / write select
//   mem_addr            word-aligned address
//   mem_wdata/mem_wmask lane-positioned store data and byte strobes
//   mem_ready/mem_rdata memory accept/complete and read data
// -----------------------------------------------------------------------------
module ysyx_20020207_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exu_valid,
  output logic        exu_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_result,
  output logic        lsu_finish,
  output logic [31:0] wb_data,
  output logic        lsu_fault,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero MAX_WAIT disables the timeout; keep the counter at least one bit
  // wide so the declaration stays legal.
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam bit TIMEOUT_EN = (MAX_WAIT > 0);
  localparam logic [CNT_W-1:0] WAIT_LAST =
    (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

  state_t           state;
  logic             op_load;
  logic [2:0]       op_funct3;
  logic [1:0]       op_off;
  logic [CNT_W-1:0] wait_cnt;

  logic             is_mem;
  logic             trap;
  logic [3:0]       req_mask;
  logic [31:0]      req_wdata;
  logic [15:0]      lane;
  logic [31:0]      load_data;

  // exu_ready is a decode of the state so that it is low during reset and
  // high in the very first cycle after reset is released.
  assign exu_ready = (state == IDLE) && !rst;
  assign is_mem    = is_load || is_store;

  // ---------------------------------------------------------------------------
  // Store lane placement. Byte and half data are replicated across the word so
  // the strobes alone select the lane; a half at offset 3 has its mask
  // truncated to the top byte.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    req_mask  = 4'b1111;
    req_wdata = store_data;
    case (funct3)
      3'b000: begin
        req_mask  = 4'b0001 << addr[1:0];
        req_wdata = {4{store_data[7:0]}};
      end
      3'b001: begin
        req_mask  = 4'b0011 << addr[1:0];
        req_wdata = {2{store_data[15:0]}};
      end
      default: begin
        req_mask  = 4'b1111;
        req_wdata = store_data;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Misalignment trap (optional).
  // ---------------------------------------------------------------------------
`ifdef LSU_MISALIGN_TRAP_EN
  logic acc_byte;
  logic acc_half;

  always_comb begin
    acc_byte = 1'b0;
    acc_half = 1'b0;
    if (is_load) begin
      acc_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
      acc_half = (funct3 == 3'b001) || (funct3 == 3'b101);
    end else begin
      acc_byte = (funct3 == 3'b000);
      acc_half = (funct3 == 3'b001);
    end
    // Everything that is neither byte nor half is a word access.
    trap = is_mem &&
           ((acc_half && addr[0]) ||
            (!acc_byte && !acc_half && (addr[1:0] != 2'b00)));
  end
`else
  assign trap = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Load formatting from the captured offset and funct3. The addressed byte or
  // half is brought down to bit 0 first; only the low 16 bits are needed.
  // ---------------------------------------------------------------------------
  assign lane = 16'(mem_rdata >> {op_off, 3'b000});

  always_comb begin
    load_data = mem_rdata;
    case (op_funct3)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'b0, lane[7:0]};
      3'b101:  load_data = {16'b0, lane[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: only control and visible outputs are reset; the captured op
      // fields are always written before being read.
      state      <= IDLE;
      lsu_finish <= 1'b0;
      wb_data    <= '0;
      lsu_fault  <= 1'b0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exu_valid) begin
            op_load   <= is_load;
            op_funct3 <= funct3;
            op_off    <= addr[1:0];
            wait_cnt  <= '0;
            if (!is_mem) begin
              state      <= DONE;
              lsu_finish <= 1'b1;
              wb_data    <= alu_result;
              lsu_fault  <= 1'b0;
            end else if (trap) begin
              state      <= DONE;
              lsu_finish <= 1'b1;
              wb_data    <= '0;
              lsu_fault  <= 1'b1;
            end else begin
              state     <= REQ;
              mem_valid <= 1'b1;
              mem_wen   <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wmask <= is_store ? req_mask : 4'b0000;
              mem_wdata <= is_store ? req_wdata : 32'h0;
            end
          end
        end

        REQ: begin
          // A response in the expiry cycle still completes normally.
          if (mem_ready) begin
            state      <= DONE;
            mem_valid  <= 1'b0;
            lsu_finish <= 1'b1;
            wb_data    <= op_load ? load_data : 32'h0;
            lsu_fault  <= 1'b0;
          end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
            state      <= DONE;
            mem_valid  <= 1'b0;
            lsu_finish <= 1'b1;
            wb_data    <= '0;
            lsu_fault  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state      <= IDLE;
          lsu_finish <= 1'b0;
          wb_data    <= '0;
          lsu_fault  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_20020207_lsu.sv
// -----------------------------------------------------------------------------
// Directed testbench for ysyx_20020207_lsu. Two instances share every input:
// dut uses the default MAX_WAIT, dut4 uses MAX_WAIT=4 so its timeout and the
// ready-in-expiry-cycle boundary show up during the same transactions.
// -----------------------------------------------------------------------------
module tb_ysyx_20020207_lsu;

  logic        clk;
  logic        rst;
  logic        exu_valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] alu_result;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        exu_ready,  w4_exu_ready;
  logic        lsu_finish, w4_lsu_finish;
  logic [31:0] wb_data,    w4_wb_data;
  logic        lsu_fault,  w4_lsu_fault;
  logic        mem_valid,  w4_mem_valid;
  logic        mem_wen,    w4_mem_wen;
  logic [31:0] mem_addr,   w4_mem_addr;
  logic [31:0] mem_wdata,  w4_mem_wdata;
  logic [3:0]  mem_wmask,  w4_mem_wmask;

  int vectors     = 0;
  int miscompares = 0;

  // dut4 observations gathered while a transaction runs
  int          w4_fin_cycle;
  int          w4_valid_cycles;
  logic        w4_fault_o;
  logic [31:0] w4_wb_o;

  ysyx_20020207_lsu dut (
    .clk(clk), .rst(rst), .exu_valid(exu_valid), .exu_ready(exu_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .alu_result(alu_result), .lsu_finish(lsu_finish),
    .wb_data(wb_data), .lsu_fault(lsu_fault), .mem_valid(mem_valid),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  ysyx_20020207_lsu #(.MAX_WAIT(4)) dut4 (
    .clk(clk), .rst(rst), .exu_valid(exu_valid), .exu_ready(w4_exu_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .alu_result(alu_result), .lsu_finish(w4_lsu_finish),
    .wb_data(w4_wb_data), .lsu_fault(w4_lsu_fault), .mem_valid(w4_mem_valid),
    .mem_wen(w4_mem_wen), .mem_addr(w4_mem_addr), .mem_wdata(w4_mem_wdata),
    .mem_wmask(w4_mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // Presents one instruction and returns #1 after the accepting edge.
  task automatic issue(input logic l, input logic s, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] alu);
    int budget;
    is_load    = l;
    is_store   = s;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    alu_result = alu;
    exu_valid  = 1'b1;
    budget     = 0;
    while (!exu_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    vectors++;
    if (exu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: exu_ready=%b required 1", exu_ready);
    end
    @(posedge clk); #1;
    exu_valid = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
  endtask

  task automatic sample_w4(input int cyc);
    if (w4_mem_valid === 1'b1) w4_valid_cycles++;
    if (w4_lsu_finish === 1'b1 && w4_fin_cycle == 0) begin
      w4_fin_cycle = cyc;
      w4_fault_o   = w4_lsu_fault;
      w4_wb_o      = w4_wb_data;
    end
  endtask

  // Runs one memory instruction: mem_ready stays low for 'waits' REQ cycles,
  // then rises for one cycle with 'rd'. Returns what the main dut showed.
  task automatic run_mem(input logic l, input logic s, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int waits,
                         output logic req_seen, output logic [31:0] req_addr,
                         output logic req_wen, output logic [3:0] req_mask,
                         output logic [31:0] req_wdata, output logic stable,
                         output logic fin, output logic [31:0] wb,
                         output logic fault, output logic tail_ok);
    int cyc;
    w4_fin_cycle    = 0;
    w4_valid_cycles = 0;
    w4_fault_o      = 1'b0;
    w4_wb_o         = 32'h0;
    issue(l, s, f3, a, sd, 32'h5555_5555);
    cyc = 1;
    sample_w4(cyc);
    req_seen  = mem_valid;
    req_addr  = mem_addr;
    req_wen   = mem_wen;
    req_mask  = mem_wmask;
    req_wdata = mem_wdata;
    stable    = 1'b1;
    if (req_seen === 1'b1) begin
      mem_ready = 1'b0;
      for (int k = 0; k < waits; k++) begin
        @(posedge clk); #1;
        cyc++;
        sample_w4(cyc);
        if (mem_valid !== 1'b1 ||
            {mem_addr, mem_wen, mem_wmask, mem_wdata} !==
            {req_addr, req_wen, req_mask, req_wdata})
          stable = 1'b0;
      end
      mem_ready = 1'b1;
      mem_rdata = rd;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      cyc++;
      sample_w4(cyc);
    end
    fin   = lsu_finish;
    wb    = wb_data;
    fault = lsu_fault;
    @(posedge clk); #1;
    cyc++;
    sample_w4(cyc);
    tail_ok = (lsu_finish === 1'b0) && (exu_ready === 1'b1) && (mem_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; alu_result = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({exu_ready, lsu_finish, lsu_fault, mem_valid, mem_wen, wb_data,
         mem_addr, mem_wdata, mem_wmask} !== 105'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b fin=%b fault=%b valid=%b wen=%b wb=%h addr=%h wdata=%h mask=%b required all zero",
               exu_ready, lsu_finish, lsu_fault, mem_valid, mem_wen, wb_data,
               mem_addr, mem_wdata, mem_wmask);
    end
    vectors++;
    if ({w4_exu_ready, w4_lsu_finish, w4_mem_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs_w4: ready=%b fin=%b valid=%b required 000",
               w4_exu_ready, w4_lsu_finish, w4_mem_valid);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (exu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: exu_ready=%b required 1", exu_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    issue(1'b0, 1'b0, 3'b000, 32'h8000_0000, 32'h0, 32'h1234_5678);
    vectors++;
    if ({lsu_finish, lsu_fault, mem_valid, exu_ready, wb_data} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL alu_finish: fin=%b fault=%b valid=%b ready=%b wb=%h required 1 0 0 0 12345678",
               lsu_finish, lsu_fault, mem_valid, exu_ready, wb_data);
    end
    @(posedge clk); #1;
    vectors++;
    if ({lsu_finish, exu_ready, mem_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL alu_pulse_end: fin=%b ready=%b valid=%b required 0 1 0",
               lsu_finish, exu_ready, mem_valid);
    end
  endtask

  task automatic test_load();
    logic seen, wen, stable, fin, fault, tail;
    logic [31:0] raddr, wdata, wb;
    logic [3:0] mask;
    // LB at offset 3, ready after three low cycles; for dut4 this is the
    // expiry cycle, where ready must win.
    run_mem(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 3,
            seen, raddr, wen, mask, wdata, stable, fin, wb, fault, tail);
    vectors++;
    if ({seen, raddr, wen, stable} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL lb_request: valid=%b addr=%h wen=%b stable=%b required 1 80000000 0 1",
               seen, raddr, wen, stable);
    end
    vectors++;
    if ({fin, wb, fault, tail} !== {1'b1, 32'hFFFF_FF80, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL lb_result: fin=%b wb=%h fault=%b tail=%b required 1 ffffff80 0 1",
               fin, wb, fault, tail);
    end
    vectors++;
    if (w4_fin_cycle != 5 || w4_fault_o !== 1'b0 || w4_wb_o !== 32'hFFFF_FF80) begin
      miscompares++;
      $display("FAIL ready_at_expiry: fin_cycle=%0d fault=%b wb=%h required 5 0 ffffff80",
               w4_fin_cycle, w4_fault_o, w4_wb_o);
    end
    // LBU, minimum latency: finish two cycles after accept.
    run_mem(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0,
            seen, raddr, wen, mask, wdata, stable, fin, wb, fault, tail);
    vectors++;
    if ({seen, fin, wb, fault, tail} !== {1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL lbu_result: valid=%b fin=%b wb=%h fault=%b tail=%b required 1 1 00000080 0 1",
               seen, fin, wb, fault, tail);
    end
  endtask

  task automatic test_store_timeout();
    logic seen, wen, stable, fin, fault, tail;
    logic [31:0] raddr, wdata, wb;
    logic [3:0] mask;
    // SH held for five low cycles; dut4 times out after its fourth.
    run_mem(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hAAAA_BEEF, 32'h0, 5,
            seen, raddr, wen, mask, wdata, stable, fin, wb, fault, tail);
    vectors++;
    if ({seen, raddr, wen, mask, wdata} !==
        {1'b1, 32'h8000_0000, 1'b1, 4'b1100, 32'hBEEF_BEEF}) begin
      miscompares++;
      $display("FAIL sh_request: valid=%b addr=%h wen=%b mask=%b wdata=%h required 1 80000000 1 1100 beefbeef",
               seen, raddr, wen, mask, wdata);
    end
    vectors++;
    if (stable !== 1'b1) begin
      miscompares++;
      $display("FAIL sh_stable: stable=%b required 1", stable);
    end
    vectors++;
    if ({fin, wb, fault, tail} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL sh_result: fin=%b wb=%h fault=%b tail=%b required 1 00000000 0 1",
               fin, wb, fault, tail);
    end
    vectors++;
    if (w4_valid_cycles != 4 || w4_fin_cycle != 5 || w4_fault_o !== 1'b1 ||
        w4_wb_o !== 32'h0) begin
      miscompares++;
      $display("FAIL timeout: valid_cycles=%0d fin_cycle=%0d fault=%b wb=%h required 4 5 1 00000000",
               w4_valid_cycles, w4_fin_cycle, w4_fault_o, w4_wb_o);
    end
  endtask

  task automatic test_misalign();
    logic seen, wen, stable, fin, fault, tail;
    logic [31:0] raddr, wdata, wb;
    logic [3:0] mask;
    run_mem(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h1122_3344, 0,
            seen, raddr, wen, mask, wdata, stable, fin, wb, fault, tail);
`ifdef LSU_MISALIGN_TRAP_EN
    vectors++;
    if ({seen, fin, fault, wb, tail} !== {1'b0, 1'b1, 1'b1, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL lw_misalign_trap: valid=%b fin=%b fault=%b wb=%h tail=%b required 0 1 1 00000000 1",
               seen, fin, fault, wb, tail);
    end
`else
    vectors++;
    if ({seen, raddr, fin, fault, tail} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL lw_misalign_issue: valid=%b addr=%h fin=%b fault=%b tail=%b required 1 80000000 1 0 1",
               seen, raddr, fin, fault, tail);
    end
`endif
    // SH at offset 3: mask truncated to the top byte when issued.
    run_mem(1'b0, 1'b1, 3'b001, 32'h8000_0007, 32'h0000_1234, 32'h0, 0,
            seen, raddr, wen, mask, wdata, stable, fin, wb, fault, tail);
`ifdef LSU_MISALIGN_TRAP_EN
    vectors++;
    if ({seen, fin, fault} !== 3'b011) begin
      miscompares++;
      $display("FAIL sh_off3_trap: valid=%b fin=%b fault=%b required 0 1 1", seen, fin, fault);
    end
`else
    vectors++;
    if ({seen, raddr, mask, wdata, fault} !==
        {1'b1, 32'h8000_0004, 4'b1000, 32'h1234_1234, 1'b0}) begin
      miscompares++;
      $display("FAIL sh_off3_issue: valid=%b addr=%h mask=%b wdata=%h fault=%b required 1 80000004 1000 12341234 0",
               seen, raddr, mask, wdata, fault);
    end
`endif
  endtask

  typedef struct {
    logic        l;
    logic        s;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  task automatic test_formats();
    vec_t v[9];
    logic seen, wen, stable, fin, fault, tail;
    logic [31:0] raddr, wdata, wb;
    logic [3:0] mask;
    v[0] = '{1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_1234, 32'h8000_0000, 4'b0, 32'h0, 32'hFFFF_8001};
    v[1] = '{1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_1234, 32'h8000_0000, 4'b0, 32'h0, 32'h0000_8001};
    v[2] = '{1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 32'h8000_0010, 4'b0, 32'h0, 32'hDEAD_BEEF};
    v[3] = '{1'b1, 1'b0, 3'b000, 32'h8000_0000, 32'h0, 32'h1234_567F, 32'h8000_0000, 4'b0, 32'h0, 32'h0000_007F};
    v[4] = '{1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_A500, 32'h8000_0000, 4'b0, 32'h0, 32'hFFFF_FFA5};
    v[5] = '{1'b1, 1'b0, 3'b011, 32'h8000_0020, 32'h0, 32'h0BAD_F00D, 32'h8000_0020, 4'b0, 32'h0, 32'h0BAD_F00D};
    v[6] = '{1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h0, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    v[7] = '{1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'h1234_5678, 32'h0, 32'h8000_0004, 4'b1111, 32'h1234_5678, 32'h0};
    v[8] = '{1'b0, 1'b1, 3'b111, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 32'h8000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0};
    for (int i = 0; i < 9; i++) begin
      run_mem(v[i].l, v[i].s, v[i].f3, v[i].a, v[i].sd, v[i].rd, i % 3,
              seen, raddr, wen, mask, wdata, stable, fin, wb, fault, tail);
      vectors++;
      if ({seen, raddr, wen, stable} !== {1'b1, v[i].exp_addr, v[i].s, 1'b1} ||
          (v[i].s && {mask, wdata} !== {v[i].exp_mask, v[i].exp_wdata})) begin
        miscompares++;
        $display("FAIL fmt_request[%0d]: valid=%b addr=%h wen=%b stable=%b mask=%b wdata=%h required 1 %h %b 1 %b %h",
                 i, seen, raddr, wen, stable, mask, wdata, v[i].exp_addr, v[i].s,
                 v[i].exp_mask, v[i].exp_wdata);
      end
      vectors++;
      if ({fin, wb, fault, tail} !== {1'b1, v[i].exp_wb, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL fmt_result[%0d]: fin=%b wb=%h fault=%b tail=%b required 1 %h 0 1",
                 i, fin, wb, fault, tail, v[i].exp_wb);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0001);
    // Hold the next instruction while the stage is in DONE; it must wait.
    alu_result = 32'h0000_0002;
    exu_valid  = 1'b1;
    vectors++;
    if ({lsu_finish, exu_ready, wb_data} !== {1'b1, 1'b0, 32'h1}) begin
      miscompares++;
      $display("FAIL b2b_first: fin=%b ready=%b wb=%h required 1 0 00000001",
               lsu_finish, exu_ready, wb_data);
    end
    @(posedge clk); #1;
    vectors++;
    if ({lsu_finish, exu_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_idle: fin=%b ready=%b required 0 1", lsu_finish, exu_ready);
    end
    @(posedge clk); #1;
    exu_valid = 1'b0;
    vectors++;
    if ({lsu_finish, wb_data} !== {1'b1, 32'h2}) begin
      miscompares++;
      $display("FAIL b2b_second: fin=%b wb=%h required 1 00000002", lsu_finish, wb_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic quiet;
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0);
    vectors++;
    if (mem_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_req: mem_valid=%b required 1", mem_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({mem_valid, exu_ready, lsu_finish, w4_mem_valid, w4_lsu_finish} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_mid_abort: valid=%b ready=%b fin=%b w4_valid=%b w4_fin=%b required 00000",
               mem_valid, exu_ready, lsu_finish, w4_mem_valid, w4_lsu_finish);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (exu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_release: exu_ready=%b required 1", exu_ready);
    end
    // A stray mem_ready in IDLE must be ignored.
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (lsu_finish !== 1'b0 || mem_valid !== 1'b0 || exu_ready !== 1'b1) quiet = 1'b0;
    end
    vectors++;
    if (quiet !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: quiet=%b required 1 (no finish/valid after abort)", quiet);
    end
    mem_rdata = 32'h0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_timeout();
    test_misalign();
    test_formats();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_20020207_lsu.md
# ysyx_20020207_lsu

Load/store unit for the 32-bit multi-cycle RISC-V core, sitting between execute and the register file. Accepts one instruction from execute and runs any data-memory access over a valid/ready port. Formats load data or passes the ALU result through. Pulses `lsu_finish` to qualify the register-file write of `wb_data`.

## Interface
- `MAX_WAIT`, 255: cycles to wait for `mem_ready` before aborting; 0 = wait forever.
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `exu_valid`  in  1  execute has an instruction for this stage
- `exu_ready`  out  1  stage idle; transfer on `exu_valid && exu_ready`
- `is_load` / `is_store`  in  1 each  memory op type; never both high
- `funct3`  in  3  RV32I width/sign code
- `addr`  in  32  effective address
- `store_data`  in  32  rs2 value
- `alu_result`  in  32  writeback value for non-memory ops
- `lsu_finish`  out  1  one-cycle pulse; register file writes when high
- `wb_data`  out  32  writeback value, valid while `lsu_finish`=1
- `lsu_fault`  out  1  misalign/timeout flag, valid while `lsu_finish`=1
- `mem_valid`  out  1  memory request
- `mem_wen`  out  1  1 = write
- `mem_addr`  out  32  word-aligned address
- `mem_wdata`  out  32  lane-positioned store data
- `mem_wmask`  out  4  byte strobes
- `mem_ready`  in  1  request accepted/completed this cycle
- `mem_rdata`  in  32  read data, valid with `mem_ready`

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: `exu_ready`=1.
  - On transfer, register op, `funct3`, `addr`, `store_data` and `alu_result`.
  - Memory op → REQ; otherwise → DONE.
- REQ: `mem_valid`=1; all `mem_*` outputs stay stable until `mem_ready`=1.
  - On `mem_ready`: capture `mem_rdata` and go to DONE.
- DONE: `lsu_finish`=1 for exactly one cycle, then → IDLE.
- `mem_addr` = {addr[31:2], 2'b00}; off = addr[1:0].
- Store strobes and data:
  - SB (000): mask 4'b0001<<off; data = {4{store_data[7:0]}}.
  - SH (001): mask 4'b0011<<off, truncated to 4 bits; data = {2{store_data[15:0]}}.
  - SW (010): mask 4'b1111; data = store_data.
  - Any other funct3 is treated as SW.
- Load formatting: byte/half is selected by `rdata >> (8*off)`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Any other funct3 is treated as LW.
- `wb_data` per op: non-memory → `alu_result`; store → 0; load → formatted data.
- Timeout: if `MAX_WAIT`≠0 and `mem_ready` stays low for `MAX_WAIT` consecutive REQ cycles:
  - drop `mem_valid` and go to DONE;
  - `wb_data`=0 and `lsu_fault`=1.
  - The wait counter is sized ceil(log2(MAX_WAIT+1)) and cleared on REQ entry.

## Timing
- Reset values: state IDLE; `exu_ready`=0 while `rst`=1; all other outputs 0.
- Non-memory op: accepted at edge N, `lsu_finish` high in cycle N+1.
- Memory op: accepted at N; `mem_valid` high from N+1.
  - With `mem_ready` in cycle N+1, `lsu_finish` is high in cycle N+2 (minimum latency).
- `exu_ready`=0 in REQ and DONE. The next instruction can transfer in the cycle after DONE.
- `mem_ready` is ignored outside REQ.
- `exu_valid` while not ready is ignored; execute must hold it.
- Reset mid-transaction: next edge returns to IDLE and `mem_valid`=0. No `lsu_finish` is produced for the aborted op.
- `mem_ready` arriving in the same cycle the timeout expires: `mem_ready` wins, giving a normal completion with `lsu_fault`=0.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are trapped: LH/LHU/SH with addr[0]=1, or LW/SW with off≠0.
  - A trapped access issues no memory request; it goes IDLE→DONE with `lsu_fault`=1 and `wb_data`=0.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No alignment check; the access is issued with the shifted, truncated mask/lane.
  - `lsu_fault` is set only on timeout.

## Test plan
- ADD with `alu_result`=0x1234_5678 → `lsu_finish` one cycle after accept, `wb_data`=0x1234_5678, no `mem_valid`.
- LB at 0x8000_0003, `mem_rdata`=0x80FF_0000, `mem_ready` after 3 cycles → `mem_addr`=0x8000_0000, `wb_data`=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x8000_0002 with `store_data`=0xAAAA_BEEF → `mem_wen`=1, `mem_wmask`=4'b1100, `mem_wdata`=0xBEEF_BEEF. Outputs are held stable while `mem_ready`=0 for 5 cycles.
- LW at 0x8000_0001 with the macro defined → no `mem_valid`, `lsu_finish`=1 with `lsu_fault`=1. Without the macro → request at 0x8000_0000, `lsu_fault`=0.
- `MAX_WAIT`=4 and `mem_ready` held low → `mem_valid` drops after 4 cycles; `lsu_finish`=1, `lsu_fault`=1, `wb_data`=0.
- `rst` asserted during REQ → `mem_valid`=0 and `exu_ready`=0 next cycle, no `lsu_finish`. `exu_ready`=1 in the first cycle after `rst` deasserts.
